boot_ram: RTL and testbench
===========================

Name: boot_ram

Overview:
Byte-addressed RAM that is filled at boot from a streaming byte loader and then serves the core's instruction/data fetch port. The read port has the same signal set and semantics as genrom, so the core's mem_* bus connects to it unchanged. This lets benches and SoC top levels stream WASM bytecode into the core instead of baking it into a hex file. While loading is incomplete, every fetch returns an error, so the core traps rather than executing stale bytes.

Parameters:
AW, 4, address bits of storage; depth DEPTH = 2**AW bytes; the read address bus is AW+1 bits wide.
EXTRA, 4, width of the extra field; read data is 2**EXTRA bytes wide.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
load_valid  in  1  loader byte valid.
load_ready  out  1  RAM can accept a loader byte.
load_data  in  8  loader byte.
load_last  in  1  marks the final byte of the image; qualified by load_valid.
loaded  out  1  image complete; reads are enabled.
load_error  out  1  image overflowed DEPTH.
load_count  out  AW+1  number of bytes accepted so far.
addr  in  AW+1  read start byte address.
extra  in  EXTRA  number of additional bytes requested beyond addr; the read covers extra+1 bytes.
lower_bound  in  AW+1  lowest legal address, inclusive.
upper_bound  in  AW+1  highest legal address, inclusive.
data  out  2**EXTRA*8  read data; byte i sits in bits [8i+7:8i].
error  out  1  read fault.

Behaviour:
- Reset (asynchronous, active-high) puts the block in LOAD with:
  - load_count=0, loaded=0, load_error=0, load_ready=1 once reset deasserts;
  - data=0, error=1.
  - Storage contents are not reset.
- Load FSM has three states: LOAD, DONE, OVERFLOW.
- LOAD:
  - load_ready=1.
  - A beat is accepted when load_valid and load_ready are both high on a rising edge.
  - Accepted beat with load_count<DEPTH: mem[load_count]<=load_data, load_count++.
    - If load_last=1 as well: go to DONE; loaded=1 from the next cycle.
  - Accepted beat with load_count==DEPTH: byte is dropped, go to OVERFLOW.
  - A zero-length image is impossible; at least one beat carries load_last.
- DONE: load_ready=0, loaded=1, load_count frozen. Further load_valid is ignored. Only reset leaves DONE.
- OVERFLOW: load_ready=0, load_error=1, loaded=0, load_count=DEPTH. Only reset leaves OVERFLOW.
- load_valid held high with load_ready=0 has no effect. Gaps in load_valid are allowed and carry no state meaning.
- Read port: synchronous, 1-cycle latency, one read every cycle with no handshake. Inputs sampled at edge N give data/error after edge N.
- Error computation, with end = addr + extra evaluated at AW+2 bits (no wrap). error<=1 if any of:
  - loaded==0;
  - addr < lower_bound;
  - end > upper_bound;
  - end >= DEPTH.
- On error: data<=0.
- Otherwise: data byte i <= mem[addr+i] for i <= extra; bytes i > extra <= 0.
- A read in the same cycle as the load_last beat still reports error=1. The first valid read is sampled on the edge after loaded rises.
- Reset mid-load: count and FSM return to LOAD; partial contents become inaccessible until the new image completes. Reset mid-read forces data=0 and error=1 immediately (asynchronous).
- Bounds are sampled each cycle with addr; changing the bounds affects only the next result.

Test Plan:
- Load bytes 00 61 73 6D 01 with last on the 5th, AW=4, bounds 0..31. Then read addr=0, extra=3 -> data[31:0]=0x6D736100, upper bytes 0, error=0, loaded=1, load_count=5.
- Read addr=0, extra=0 before any load -> error=1, data=0. Load 1 byte with last; the read on the edge after loaded rises -> error=0.
- AW=4: stream 16 bytes without last (load_count=16, load_ready=1), then a 17th beat -> load_error=1, load_ready=0, loaded=0, every read error=1.
- After loading 16 bytes (last on the 16th):
  - lower_bound=2, addr=1 -> error=1;
  - addr=14, extra=1 -> error=0, bytes 14 and 15 returned;
  - addr=15, extra=1 -> error=1 (end=16 >= DEPTH).
- Load with load_valid toggling every other cycle and extra pulses while load_ready=0 after DONE -> load_count equals the number of handshaked beats; bytes after load_last do not change memory.
- Assert reset after 3 of 5 bytes -> loaded=0, load_count=0, error=1. Reload 2 bytes AA BB with last -> read addr=0, extra=1 gives 0xBBAA.

Source files
------------

// File: rtl/boot_ram_if.sv
// Loader stream plus genrom-compatible fetch bus for boot_ram.
// Carries signals only; it adds no timing of its own.
// The slave side is the RAM and the master side is the loader/core.
interface boot_ram_if #(
    parameter int AW    = 4,
    parameter int EXTRA = 4
);
    localparam int DW = (2**EXTRA) * 8;

    // Boot loader byte stream
    logic              load_valid;
    logic              load_ready;
    logic [7:0]        load_data;
    logic              load_last;
    logic              loaded;
    logic              load_error;
    logic [AW:0]       load_count;

    // Fetch port (same semantics as genrom)
    logic [AW:0]       addr;
    logic [EXTRA-1:0]  extra;
    logic [AW:0]       lower_bound;
    logic [AW:0]       upper_bound;
    logic [DW-1:0]     data;
    logic              error;

    modport slave (
        input  load_valid, load_data, load_last,
        input  addr, extra, lower_bound, upper_bound,
        output load_ready, loaded, load_error, load_count,
        output data, error
    );

    modport master (
        output load_valid, load_data, load_last,
        output addr, extra, lower_bound, upper_bound,
        input  load_ready, loaded, load_error, load_count,
        input  data, error
    );
endinterface

// File: rtl/boot_ram.sv
// Byte RAM filled once from a streaming loader, then read through a genrom-style fetch port.
// Fetch latency is 1 cycle; loader beats are written on the accepting edge.
// The loader stalls (load_ready=0) once the image is done or has overflowed; fetch has no backpressure.
module boot_ram #(
    parameter int AW    = 4,
    parameter int EXTRA = 4
) (
    input  logic       clk,
    input  logic       reset,
    boot_ram_if.slave  bus
);
    localparam int DEPTH = 2**AW;
    localparam int NB    = 2**EXTRA;
    localparam int DW    = NB * 8;
    localparam int EW    = AW + 2;

    typedef logic [EW-1:0] ext_t;
    typedef enum logic [1:0] {ST_LOAD, ST_DONE, ST_OVF} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic            mem_we;
    logic [7:0]      mem [DEPTH];

    logic [DW-1:0]   data_q, data_d;
    logic            error_q, error_d;
    ext_t            end_w;
    ext_t            idx;

    // Load FSM state and byte counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Load FSM next state: accept beats only in LOAD, drop the one beyond DEPTH
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.load_valid) begin
                    if (count_q < (AW+1)'(DEPTH)) begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                        if (bus.load_last) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_OVF;
                    end
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_OVF:  state_d = ST_OVF;
            default: state_d = ST_LOAD;
        endcase
    end

    // Storage write; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[count_q[AW-1:0]] <= bus.load_data;
        end
    end

    // Fetch check and byte gather; end address kept two bits wider so it never wraps
    always_comb begin
        end_w   = ext_t'(bus.addr) + ext_t'(bus.extra);
        error_d = (state_q != ST_DONE)
               || (bus.addr < bus.lower_bound)
               || (end_w > ext_t'(bus.upper_bound))
               || (end_w >= ext_t'(DEPTH));
        data_d  = '0;
        idx     = '0;
        for (int i = 0; i < NB; i++) begin
            idx = ext_t'(bus.addr) + ext_t'(i);
            if (!error_d && (i <= int'(bus.extra))) begin
                data_d[8*i +: 8] = mem[idx[AW-1:0]];
            end
        end
    end

    // Fetch result register; reset forces a faulting, zero result immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            error_q <= 1'b1;
        end else begin
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign bus.load_ready = (state_q == ST_LOAD);
    assign bus.loaded     = (state_q == ST_DONE);
    assign bus.load_error = (state_q == ST_OVF);
    assign bus.load_count = count_q;
    assign bus.data       = data_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_boot_ram.sv
// Directed bench for boot_ram: load phases by hand, fetch checks from a vector table.
module tb_boot_ram;
    localparam int AW    = 4;
    localparam int EXTRA = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    boot_ram_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

    boot_ram #(.AW(AW), .EXTRA(EXTRA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [4:0]   addr;
        logic [3:0]   extra;
        logic [4:0]   lo;
        logic [4:0]   hi;
        logic         exp_err;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one loader beat for one cycle (called at a negedge, returns at the next negedge)
    task automatic load_byte(input logic [7:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] a, input logic [3:0] e, input logic [4:0] lo, input logic [4:0] hi);
        bus.addr        = a;
        bus.extra       = e;
        bus.lower_bound = lo;
        bus.upper_bound = hi;
    endtask

    task automatic do_reset();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.load_last  = 1'b0;
        set_read(5'd0, 4'd0, 5'd0, 5'd31);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_data", bus.data, 128'h0);
        check("rst_error", 128'(bus.error), 128'h1);
        check("rst_loaded", 128'(bus.loaded), 128'h0);
        check("rst_load_error", 128'(bus.load_error), 128'h0);
        check("rst_count", 128'(bus.load_count), 128'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 128'(bus.load_ready), 128'h1);

        // Read before load faults; read on the last-beat edge still faults; next one is good
        check("preload_error", 128'(bus.error), 128'h1);
        check("preload_data", bus.data, 128'h0);
        load_byte(8'h5A, 1'b1);
        check("lastedge_error", 128'(bus.error), 128'h1);
        check("lastedge_loaded", 128'(bus.loaded), 128'h1);
        @(negedge clk);
        check("firstread_error", 128'(bus.error), 128'h0);
        check("firstread_data", bus.data, 128'h5A);

        // Gapped load of a 5-byte image, then beats offered while not ready
        do_reset();
        load_byte(8'h00, 1'b0); @(negedge clk);
        load_byte(8'h61, 1'b0); @(negedge clk);
        load_byte(8'h73, 1'b0); @(negedge clk);
        load_byte(8'h6D, 1'b0); @(negedge clk);
        load_byte(8'h01, 1'b1); @(negedge clk);
        load_byte(8'hFF, 1'b0);
        load_byte(8'hEE, 1'b1);
        check("img5_count", 128'(bus.load_count), 128'd5);
        check("img5_loaded", 128'(bus.loaded), 128'h1);
        check("img5_ready", 128'(bus.load_ready), 128'h0);
        set_read(5'd0, 4'd3, 5'd0, 5'd31);
        @(negedge clk);
        check("img5_read_error", 128'(bus.error), 128'h0);
        check("img5_read_data", bus.data, 128'h6D736100);
        set_read(5'd2, 4'd2, 5'd0, 5'd31);
        @(negedge clk);
        check("img5_read2_data", bus.data, 128'h016D73);

        // Asynchronous reset in the middle of valid reads
        #2 reset = 1'b1;
        #1;
        check("async_rst_error", 128'(bus.error), 128'h1);
        check("async_rst_data", bus.data, 128'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset after 3 of 5 bytes, then reload a short image
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        load_byte(8'h33, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midload_loaded", 128'(bus.loaded), 128'h0);
        check("midload_count", 128'(bus.load_count), 128'h0);
        check("midload_error", 128'(bus.error), 128'h1);
        reset = 1'b0;
        set_read(5'd0, 4'd1, 5'd0, 5'd31);
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b1);
        @(negedge clk);
        check("reload_error", 128'(bus.error), 128'h0);
        check("reload_data", bus.data, 128'hBBAA);

        // Overflow: 16 bytes without last, then a 17th
        do_reset();
        set_read(5'd0, 4'd0, 5'd0, 5'd31);
        for (int k = 0; k < 16; k++) load_byte(8'(k), 1'b0);
        check("full_count", 128'(bus.load_count), 128'd16);
        check("full_ready", 128'(bus.load_ready), 128'h1);
        check("full_loaded", 128'(bus.loaded), 128'h0);
        load_byte(8'h99, 1'b0);
        load_byte(8'h98, 1'b1);
        check("ovf_load_error", 128'(bus.load_error), 128'h1);
        check("ovf_ready", 128'(bus.load_ready), 128'h0);
        check("ovf_loaded", 128'(bus.loaded), 128'h0);
        check("ovf_count", 128'(bus.load_count), 128'd16);
        check("ovf_read_error", 128'(bus.error), 128'h1);

        // Full 16-byte image A0..AF, then the fetch vector table
        do_reset();
        for (int k = 0; k < 16; k++) load_byte(8'hA0 + 8'(k), (k == 15));
        check("img16_loaded", 128'(bus.loaded), 128'h1);
        check("img16_count", 128'(bus.load_count), 128'd16);

        vecs[0] = '{"t_word0",   5'd0,  4'd3,  5'd0, 5'd31, 1'b0, 128'hA3A2A1A0};
        vecs[1] = '{"t_below",   5'd1,  4'd0,  5'd2, 5'd31, 1'b1, 128'h0};
        vecs[2] = '{"t_top2",    5'd14, 4'd1,  5'd0, 5'd31, 1'b0, 128'hAFAE};
        vecs[3] = '{"t_past",    5'd15, 4'd1,  5'd0, 5'd31, 1'b1, 128'h0};
        vecs[4] = '{"t_last",    5'd15, 4'd0,  5'd0, 5'd31, 1'b0, 128'hAF};
        vecs[5] = '{"t_upper",   5'd4,  4'd2,  5'd0, 5'd5,  1'b1, 128'h0};
        vecs[6] = '{"t_uppereq", 5'd4,  4'd1,  5'd0, 5'd5,  1'b0, 128'hA5A4};
        vecs[7] = '{"t_all",     5'd0,  4'd15, 5'd0, 5'd31, 1'b0,
                    128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
        vecs[8] = '{"t_depth",   5'd16, 4'd0,  5'd0, 5'd31, 1'b1, 128'h0};
        vecs[9] = '{"t_pinned",  5'd3,  4'd0,  5'd3, 5'd3,  1'b0, 128'hA3};

        for (int v = 0; v < 10; v++) begin
            set_read(vecs[v].addr, vecs[v].extra, vecs[v].lo, vecs[v].hi);
            @(negedge clk);
            check({vecs[v].name, "_error"}, 128'(bus.error), 128'(vecs[v].exp_err));
            check({vecs[v].name, "_data"}, bus.data, vecs[v].exp_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
